timer_irq_responder: RTL and testbench
======================================

// Module: timer_irq_responder
// PURPOSE
//  Memory-mapped timer/interrupt peripheral; the responder end of the CPU's MEM-stage data bus
//  (rd/wr/addr/wdata/rdata). Provides a reloadable 32-bit up-counter with prescaler, a sticky
//  overflow flag driving irqout to the CPU's Control IRQ input, and a free-running cycle counter.
//  Sits beside DataMem on the bus; the CPU selects peripheral space by addr[30].
// PARAMETERS
//  BASE_ADDR  32'h4000_0000  window base; block decodes addr[31:5]==BASE_ADDR[31:5]
//  PSC_W      8              prescaler register/counter width
// PORTS
//  clk      in   1   system clock
//  reset    in   1   asynchronous, active-high reset
//  rd       in   1   bus read strobe (MEM stage)
//  wr       in   1   bus write strobe (MEM stage)
//  addr     in   32  byte address; addr[1:0] ignored
//  wdata    in   32  write data
//  rdata    out  32  read data, combinational
//  irqout   out  1   interrupt request, level, = TCON[1] & TCON[2]
// BEHAVIOUR
//  Register map (offset = addr[4:2]):
//   0 TH   rw  reload value             1 TL   rw  counter
//   2 TCON rw  [0]=EN [1]=IE [2]=OVF    3 PSC  rw  [PSC_W-1:0] prescale, tick every PSC+1 clk
//   4 SYS  ro  free-running clk count   5-7 reserved: read 0, writes ignored
//  Reset (async, reset=1): TH=TL=0, TCON=0, PSC=0, prescale cnt=0, SYS=0; irqout=0.
//  Read: rdata = selected register when rd && window hit, else 32'd0; zero latency (same cycle
//   as rd); unused TCON/PSC bits read 0. Reads have no side effects.
//  Write: at posedge clk when wr && hit. rd&&wr together: write proceeds, rdata shows old value.
//   TCON write: EN<=wdata[0], IE<=wdata[1]; OVF cleared if wdata[2]==0, unchanged if 1.
//   TCON write with EN 0->1 or any PSC write clears prescale counter.
//  Tick: when EN=1, prescale cnt increments each clk; when cnt==PSC, cnt<=0 and tick=1.
//   PSC=0 -> tick every cycle. EN=0 -> cnt and TL hold.
//  Count: on tick, if TL==32'hFFFF_FFFF then TL<=TH and OVF<=1 (set regardless of IE);
//   else TL<=TL+1. Wrap fixed at all-ones, no carry out.
//  Priority same cycle: bus write to TL beats tick update of TL; OVF set by overflow beats
//   software clear of OVF; write to TH takes effect for the next reload only.
//  SYS increments every clk regardless of EN, wraps 32'hFFFF_FFFF->0; writes ignored.
//  irqout: combinational from TCON flops, no glitch from bus; stays high until software clears
//   OVF or IE; reset mid-count drops irqout immediately (async).
//  No handshake/wait states: every access completes in one cycle.
// TESTING
//  reset pulse mid-count -> all regs read 0, irqout=0 within same cycle of reset assert.
//  TH=5, TL=FFFF_FFFD, PSC=0, TCON=3 -> TL FFFF_FFFE, FFFF_FFFF, 5; OVF=1, irqout=1 on 3rd clk.
//  PSC=3, TL=0, TCON=1 -> TL reaches 1 after 4 clks, 2 after 8; irqout stays 0 (IE=0), OVF=1 on wrap.
//  Overflow cycle coincides with TCON write 3 (OVF clear) -> OVF=1, irqout=1 after edge.
//  Write TL=10 in same cycle as tick -> TL reads 10 next cycle, not 11; rd offset 5 -> 0.
//  SYS read at t and t+100 clks differs by 100; write SYS=0 -> no effect; addr 0x4000_0020 -> rdata 0.

Source files
------------

// File: rtl/timer_irq_responder.sv
// Memory-mapped timer/interrupt responder on the MEM-stage data bus.
// Provides a reloadable 32-bit up-counter with a prescaler, a sticky overflow flag
// that drives irqout, and a free-running cycle counter. Every access takes one cycle.
module timer_irq_responder #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int unsigned PSC_W     = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irqout
);

   localparam logic [2:0] OFF_TH   = 3'd0;
   localparam logic [2:0] OFF_TL   = 3'd1;
   localparam logic [2:0] OFF_TCON = 3'd2;
   localparam logic [2:0] OFF_PSC  = 3'd3;
   localparam logic [2:0] OFF_SYS  = 3'd4;

   logic [31:0]      th_q, th_d;
   logic [31:0]      tl_q, tl_d;
   logic             en_q, en_d;
   logic             ie_q, ie_d;
   logic             ovf_q, ovf_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   logic [PSC_W-1:0] cnt_q, cnt_d;
   logic [31:0]      sys_q, sys_d;

   logic       hit;
   logic [2:0] off;
   logic       wr_th, wr_tl, wr_tcon, wr_psc;
   logic       tick, wrap;
   logic       unused_addr;

   // Byte-lane bits are not decoded.
   assign unused_addr = ^addr[1:0];

   // Address decode and write strobes.
   always_comb begin
      hit     = (addr[31:5] == BASE_ADDR[31:5]);
      off     = addr[4:2];
      wr_th   = wr && hit && (off == OFF_TH);
      wr_tl   = wr && hit && (off == OFF_TL);
      wr_tcon = wr && hit && (off == OFF_TCON);
      wr_psc  = wr && hit && (off == OFF_PSC);
   end

   // Prescaler tick and all-ones wrap detection.
   always_comb begin
      tick = en_q && (cnt_q == psc_q);
      wrap = tick && (tl_q == 32'hFFFF_FFFF);
   end

   // Next-state logic for all registers.
   always_comb begin
      th_d  = th_q;
      tl_d  = tl_q;
      en_d  = en_q;
      ie_d  = ie_q;
      ovf_d = ovf_q;
      psc_d = psc_q;
      cnt_d = cnt_q;
      sys_d = sys_q + 32'd1;

      if (en_q) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
      // Enabling the timer or reprogramming the divider restarts the prescale period.
      if ((wr_tcon && wdata[0] && !en_q) || wr_psc) begin
         cnt_d = '0;
      end

      if (tick) begin
         tl_d = wrap ? th_q : tl_q + 32'd1;
      end
      // Software write to TL wins over the tick update.
      if (wr_tl) begin
         tl_d = wdata;
      end

      if (wr_th) begin
         th_d = wdata;
      end
      if (wr_psc) begin
         psc_d = wdata[PSC_W-1:0];
      end

      if (wr_tcon) begin
         en_d = wdata[0];
         ie_d = wdata[1];
         if (!wdata[2]) begin
            ovf_d = 1'b0;
         end
      end
      // Hardware overflow beats a same-cycle software clear so no event is lost.
      if (wrap) begin
         ovf_d = 1'b1;
      end
   end

   // Register state with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th_q  <= '0;
         tl_q  <= '0;
         en_q  <= 1'b0;
         ie_q  <= 1'b0;
         ovf_q <= 1'b0;
         psc_q <= '0;
         cnt_q <= '0;
         sys_q <= '0;
      end else begin
         th_q  <= th_d;
         tl_q  <= tl_d;
         en_q  <= en_d;
         ie_q  <= ie_d;
         ovf_q <= ovf_d;
         psc_q <= psc_d;
         cnt_q <= cnt_d;
         sys_q <= sys_d;
      end
   end

   // Zero-latency read mux; reads outside the window or while idle return 0.
   always_comb begin
      rdata = 32'd0;
      if (rd && hit) begin
         case (off)
            OFF_TH:   rdata = th_q;
            OFF_TL:   rdata = tl_q;
            OFF_TCON: rdata = {29'd0, ovf_q, ie_q, en_q};
            OFF_PSC:  rdata = {{(32 - PSC_W){1'b0}}, psc_q};
            OFF_SYS:  rdata = sys_q;
            default:  rdata = 32'd0;
         endcase
      end
   end

   // Interrupt request straight from flops so bus activity cannot glitch it.
   always_comb begin
      irqout = ie_q && ovf_q;
   end

endmodule

// File: tb/tb_timer_irq_responder.sv
// Self-checking bench for timer_irq_responder: directed scenarios followed by
// randomized bus traffic, all compared against a behavioural register-map model.
module tb_timer_irq_responder;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam logic [31:0] A_TH = BASE + 32'h0;
   localparam logic [31:0] A_TL = BASE + 32'h4;
   localparam logic [31:0] A_TC = BASE + 32'h8;
   localparam logic [31:0] A_PS = BASE + 32'hC;
   localparam logic [31:0] A_SY = BASE + 32'h10;
   localparam logic [31:0] A_R5 = BASE + 32'h14;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd, wr;
   logic [31:0] addr, wdata, rdata;
   logic        irqout;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [31:0] m_th, m_tl, m_sys;
   bit          m_en, m_ie, m_ovf;
   int unsigned m_psc;      // divide ratio minus one
   int unsigned m_elapsed;  // enabled cycles since last tick / restart
   logic [31:0] last_rdata;
   logic [31:0] v1, v2;

   timer_irq_responder #(.BASE_ADDR(BASE), .PSC_W(8)) dut (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
      .wdata(wdata), .rdata(rdata), .irqout(irqout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_window(input logic [31:0] a);
      return a[31:5] == BASE[31:5];
   endfunction

   task automatic model_reset();
      m_th = 0; m_tl = 0; m_sys = 0;
      m_en = 0; m_ie = 0; m_ovf = 0;
      m_psc = 0; m_elapsed = 0;
   endtask

   function automatic logic [31:0] model_read(input bit r, input logic [31:0] a);
      if (!r || !in_window(a)) return 32'd0;
      case (a[4:2])
         3'd0: return m_th;
         3'd1: return m_tl;
         3'd2: return {29'd0, m_ovf, m_ie, m_en};
         3'd3: return m_psc;
         3'd4: return m_sys;
         default: return 32'd0;
      endcase
   endfunction

   // One clock of the register-map rules, applied to the pre-edge state.
   task automatic model_step(input bit w, input logic [31:0] a, input logic [31:0] d);
      bit          wh = w && in_window(a);
      int unsigned o = a[4:2];
      bit          tick = m_en && (m_elapsed == m_psc);
      bit          ovf_evt = tick && (m_tl == 32'hFFFF_FFFF);
      logic [31:0] tl_n = m_tl;
      bit          restart;
      if (tick) tl_n = ovf_evt ? m_th : m_tl + 1;
      if (m_en) m_elapsed = tick ? 0 : m_elapsed + 1;
      restart = wh && ((o == 2 && d[0] && !m_en) || o == 3);
      if (restart) m_elapsed = 0;
      if (wh && o == 1) tl_n = d;
      if (wh && o == 2) begin
         m_en = d[0];
         m_ie = d[1];
         if (!d[2]) m_ovf = 0;
      end
      if (ovf_evt) m_ovf = 1;
      if (wh && o == 0) m_th = d;
      if (wh && o == 3) m_psc = d[7:0];
      m_tl  = tl_n;
      m_sys = m_sys + 1;
   endtask

   // One bus cycle: drive at negedge, check combinational outputs, then advance model.
   task automatic bus(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      rd = r; wr = w; addr = a; wdata = d;
      #1;
      last_rdata = rdata;
      check_eq("rdata", rdata, model_read(r, a));
      check_eq("irqout", {31'd0, irqout}, {31'd0, m_ie & m_ovf});
      @(posedge clk);
      model_step(w, a, d);
   endtask

   initial begin
      rd = 0; wr = 0; addr = 0; wdata = 0;
      reset = 1'b1;
      model_reset();
      #1;
      check_eq("rst_irq", {31'd0, irqout}, 32'd0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;

      // Reset values of every offset
      for (int i = 0; i < 8; i++) bus(1, 0, BASE + 32'(i * 4), 0);

      // Overflow sequence with PSC=0
      bus(0, 1, A_TH, 32'd5);
      bus(0, 1, A_TL, 32'hFFFF_FFFD);
      bus(0, 1, A_PS, 32'd0);
      bus(0, 1, A_TC, 32'd3);
      bus(1, 0, A_TL, 0);
      check_eq("ovf_tl0", last_rdata, 32'hFFFF_FFFD);
      bus(1, 0, A_TL, 0);
      check_eq("ovf_tl1", last_rdata, 32'hFFFF_FFFE);
      bus(1, 0, A_TL, 0);
      check_eq("ovf_tl2", last_rdata, 32'hFFFF_FFFF);
      bus(1, 0, A_TL, 0);
      check_eq("ovf_tl3", last_rdata, 32'd5);
      bus(1, 0, A_TC, 0);
      check_eq("ovf_tcon", last_rdata, 32'd7);
      check_eq("ovf_irq", {31'd0, irqout}, 32'd1);

      // Prescaled counting, IE off
      bus(0, 1, A_TC, 32'd0);
      bus(0, 1, A_TL, 32'd0);
      bus(0, 1, A_PS, 32'd3);
      bus(0, 1, A_TC, 32'd1);
      repeat (4) bus(0, 0, 0, 0);
      bus(1, 0, A_TL, 0);
      check_eq("psc_tl1", last_rdata, 32'd1);
      repeat (3) bus(0, 0, 0, 0);
      bus(1, 0, A_TL, 0);
      check_eq("psc_tl2", last_rdata, 32'd2);
      bus(0, 1, A_TL, 32'hFFFF_FFFF);
      repeat (5) bus(0, 0, 0, 0);
      bus(1, 0, A_TC, 0);
      check_eq("psc_ovf", last_rdata, 32'd5);
      check_eq("psc_noirq", {31'd0, irqout}, 32'd0);

      // Overflow coinciding with a TCON write that would clear OVF
      bus(0, 1, A_TC, 32'd0);
      bus(0, 1, A_PS, 32'd0);
      bus(0, 1, A_TL, 32'hFFFF_FFFF);
      bus(0, 1, A_TC, 32'd1);
      bus(0, 1, A_TC, 32'd3);
      bus(1, 0, A_TC, 0);
      check_eq("race_tcon", last_rdata, 32'd7);
      check_eq("race_irq", {31'd0, irqout}, 32'd1);

      // TL write beats tick; reserved offset reads 0
      bus(0, 1, A_TL, 32'd10);
      bus(1, 0, A_TL, 0);
      check_eq("tlw_tl", last_rdata, 32'd10);
      bus(1, 0, A_R5, 0);
      check_eq("rsvd", last_rdata, 32'd0);

      // Asynchronous reset mid-count with irqout high
      @(negedge clk);
      rd = 1; wr = 0; addr = A_TL;
      #2 reset = 1'b1;
      #1;
      check_eq("arst_irq", {31'd0, irqout}, 32'd0);
      check_eq("arst_tl", rdata, 32'd0);
      model_reset();
      @(posedge clk);
      #2 reset = 1'b0;
      for (int i = 0; i < 5; i++) bus(1, 0, BASE + 32'(i * 4), 0);

      // Free-running counter
      bus(1, 0, A_SY, 0);
      v1 = last_rdata;
      repeat (99) bus(0, 0, 0, 0);
      bus(1, 0, A_SY, 0);
      v2 = last_rdata;
      check_eq("sys_delta", v2 - v1, 32'd100);
      bus(0, 1, A_SY, 32'd0);
      bus(1, 0, A_SY, 0);
      bus(1, 0, BASE + 32'h20, 0);
      check_eq("out_win", last_rdata, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] a, d;
         bit r, w;
         r = ($urandom_range(0, 1) == 1);
         w = ($urandom_range(0, 3) == 0);
         a = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            a = $urandom;
            if (a[31:5] == BASE[31:5]) a = a ^ 32'h8000_0000;
         end
         d = $urandom;
         case (a[4:2])
            3'd1: if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            3'd2: d = 32'($urandom_range(0, 7)) | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
            3'd3: if ($urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 3));
            default: ;
         endcase
         bus(r, w, a, d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
